prog_clk_div: RTL and testbench

PROG_CLK_DIV -- requirements
Module: prog_clk_div

---
 rtl/prog_clk_div_pkg.sv | 13 +
 rtl/clk_div_chan.sv | 55 +++++
 rtl/prog_clk_div.sv | 108 ++++++++++
 tb/tb_prog_clk_div.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the output-switch state encoding and the default reset half-period.
package prog_clk_div_pkg;

   localparam int unsigned DIV_RESET_DEF = 32'd12500000;

   typedef enum logic [1:0] {
      SW_RUN   = 2'd0,
      SW_DRAIN = 2'd1,
      SW_ARM   = 2'd2
   } sw_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/shadow half-period and toggle.
// The shadow value is adopted only when the counter wraps, so reprogramming never cuts a phase short.
module clk_div_chan
   import prog_clk_div_pkg::*;
#(
   parameter int          CNT_W     = 32,
   parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_half,
   output logic             toggle,
   output logic             tick
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DIV_RESET);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] shadow;
   logic             wrap;

   // A programmed half-period of zero behaves as the fastest legal setting.
   function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] h);
      return (h == '0) ? CNT_W'(1) : h;
   endfunction

   assign wrap = en & RST & (cnt == (eff_half(half) - CNT_W'(1)));
   assign tick = wrap;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt    <= '0;
         half   <= HALF_RST;
         toggle <= 1'b0;
      end else if (wrap) begin
         cnt    <= '0;
         half   <= shadow;
         toggle <= ~toggle;
      end else if (en) begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shadow <= HALF_RST;
      end else if (wr_en) begin
         shadow <= wr_half;
      end
   end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider with a glitch-free output selector.
// The selector drains the old clock to low, then waits for the new one to fall before handing over.
module prog_clk_div
   import prog_clk_div_pkg::*;
#(
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 32,
   parameter int unsigned DIV_RESET = DIV_RESET_DEF,
   localparam int         SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_ch,
   input  logic [CNT_W-1:0]  wr_half,
   input  logic [SEL_W-1:0]  sel,
   output logic              new_clk,
   output logic [NUM_CH-1:0] tick,
   output logic              busy,
   output logic              sel_ack
);

   logic [NUM_CH-1:0] tgl;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      clk_div_chan #(
         .CNT_W     (CNT_W),
         .DIV_RESET (DIV_RESET)
      ) u_chan (
         .CLK     (CLK),
         .RST     (RST),
         .en      (en),
         .wr_en   (wr_en && (32'(wr_ch) == i)),
         .wr_half (wr_half),
         .toggle  (tgl[i]),
         .tick    (tick[i])
      );
   end

   sw_state_t        state, state_nxt;
   logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
   logic [SEL_W-1:0] target, target_nxt;
   logic             new_clk_nxt;
   logic             sel_ack_nxt;
   logic             cur_tgl;
   logic             tgt_fall;
   logic             sel_valid;

   assign cur_tgl   = tgl[cur_sel];
   assign tgt_fall  = tick[target] & tgl[target];
   assign sel_valid = (32'(sel) < NUM_CH);
   assign busy      = (state != SW_RUN);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= SW_RUN;
         cur_sel <= '0;
         target  <= '0;
         new_clk <= 1'b0;
         sel_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         cur_sel <= cur_sel_nxt;
         target  <= target_nxt;
         new_clk <= new_clk_nxt;
         sel_ack <= sel_ack_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cur_sel_nxt = cur_sel;
      target_nxt  = target;
      new_clk_nxt = new_clk;
      sel_ack_nxt = 1'b0;
      if (en) begin
         case (state)
            SW_RUN: begin
               new_clk_nxt = cur_tgl;
               if (sel_valid && (sel != cur_sel)) begin
                  state_nxt  = SW_DRAIN;
                  target_nxt = sel;
               end
            end
            SW_DRAIN: begin
               // Let the running high phase finish before parking the output low.
               new_clk_nxt = cur_tgl;
               if (!cur_tgl) begin
                  state_nxt = SW_ARM;
               end
            end
            SW_ARM: begin
               new_clk_nxt = 1'b0;
               if (tgt_fall) begin
                  state_nxt   = SW_RUN;
                  cur_sel_nxt = target;
                  sel_ack_nxt = 1'b1;
               end
            end
            default: begin
               state_nxt = SW_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div with a countdown-based reference model.
module tb_prog_clk_div;

   localparam int NUM_CH    = 4;
   localparam int CNT_W     = 8;
   localparam int DIV_RESET = 3;
   localparam int SEL_W     = 2;

   logic              CLK     = 1'b0;
   logic              RST     = 1'b0;
   logic              en      = 1'b0;
   logic              wr_en   = 1'b0;
   logic [SEL_W-1:0]  wr_ch   = '0;
   logic [CNT_W-1:0]  wr_half = '0;
   logic [SEL_W-1:0]  sel     = '0;
   logic              new_clk;
   logic [NUM_CH-1:0] tick;
   logic              busy;
   logic              sel_ack;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: each channel counts down the cycles left in its current half-period.
   int m_left   [NUM_CH];
   int m_shadow [NUM_CH];
   bit m_tgl    [NUM_CH];
   int m_mode;   // 0 = following, 1 = finishing old high phase, 2 = waiting for new channel to fall
   int m_cur;
   int m_tgt;
   bit m_nclk;
   bit m_ack;

   prog_clk_div #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .en      (en),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_half (wr_half),
      .sel     (sel),
      .new_clk (new_clk),
      .tick    (tick),
      .busy    (busy),
      .sel_ack (sel_ack)
   );

   always #5 CLK = ~CLK;

   function automatic int eff(input int h);
      return (h == 0) ? 1 : h;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_left[c]   = eff(DIV_RESET);
         m_shadow[c] = DIV_RESET;
         m_tgl[c]    = 1'b0;
      end
      m_mode = 0;
      m_cur  = 0;
      m_tgt  = 0;
      m_nclk = 1'b0;
      m_ack  = 1'b0;
   endtask

   function automatic logic [NUM_CH-1:0] model_tick();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = en && RST && (m_left[c] == 1);
      return r;
   endfunction

   function automatic logic [NUM_CH+2:0] exp_out();
      return {m_nclk, (m_mode != 0), m_ack, model_tick()};
   endfunction

   task automatic model_step();
      logic [NUM_CH-1:0] tk;
      bit                old [NUM_CH];
      if (!RST) begin
         model_reset();
         return;
      end
      tk  = model_tick();
      old = m_tgl;
      for (int c = 0; c < NUM_CH; c++) begin
         if (tk[c]) begin
            m_tgl[c]  = !m_tgl[c];
            m_left[c] = eff(m_shadow[c]);
         end else if (en) begin
            m_left[c] = m_left[c] - 1;
         end
      end
      if (wr_en && (int'(wr_ch) < NUM_CH)) m_shadow[wr_ch] = int'(wr_half);
      m_ack = 1'b0;
      if (en) begin
         case (m_mode)
            0: begin
               m_nclk = old[m_cur];
               if (int'(sel) < NUM_CH && int'(sel) != m_cur) begin
                  m_mode = 1;
                  m_tgt  = int'(sel);
               end
            end
            1: begin
               m_nclk = old[m_cur];
               if (!old[m_cur]) m_mode = 2;
            end
            default: begin
               m_nclk = 1'b0;
               if (tk[m_tgt] && old[m_tgt]) begin
                  m_mode = 0;
                  m_cur  = m_tgt;
                  m_ack  = 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic adv();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      en  = 1'b0;
      repeat (2) @(negedge CLK);
      model_reset();
      #1;
      n_vec++; if (new_clk !== 1'b0) begin n_err++; $display("FAIL reset_new_clk got=%b exp=0", new_clk); end
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (sel_ack !== 1'b0) begin n_err++; $display("FAIL reset_sel_ack got=%b exp=0", sel_ack); end
      n_vec++; if (tick !== '0)      begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick); end
      RST = 1'b1;
      en  = 1'b1;
      sel = '0;
      adv();
   endtask

   task automatic test_basic();
      int last = -1;
      for (int i = 0; i < 24; i++) begin
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL basic cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (tick[0] === 1'b1) begin
            if (last >= 0) begin
               n_vec++;
               if (i - last != 3) begin n_err++; $display("FAIL basic_tick0_gap got=%0d exp=3", i - last); end
            end
            last = i;
         end
         adv();
      end
   endtask

   task automatic test_write();
      int last = -1;
      int gap  = 0;
      for (int i = 0; i < 40; i++) begin
         wr_en   = (i == 1);
         wr_ch   = 2'd1;
         wr_half = 8'd5;
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL write cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (tick[1] === 1'b1) begin
            if (last >= 0) gap = i - last;
            last = i;
         end
         adv();
      end
      wr_en = 1'b0;
      n_vec++;
      if (gap != 5) begin n_err++; $display("FAIL write_ch1_gap got=%0d exp=5", gap); end
   endtask

   task automatic test_switch();
      bit found = 1'b0;
      int acks = 0, len = 0, min_ph = 999;
      bit prev, first;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (m_nclk && new_clk === 1'b1) begin found = 1'b1; break; end
         adv();
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL switch_wait_high got=%b exp=1", new_clk); end
      sel   = 2'd1;
      prev  = new_clk;
      first = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL switch cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (sel_ack === 1'b1) acks++;
         if (new_clk === prev) len++;
         else begin
            if (!first && len < min_ph) min_ph = len;
            first = 1'b0;
            len   = 1;
            prev  = new_clk;
         end
         adv();
      end
      n_vec++; if (acks != 1)    begin n_err++; $display("FAIL switch_acks got=%0d exp=1", acks); end
      n_vec++; if (min_ph < 3)   begin n_err++; $display("FAIL switch_min_phase got=%0d exp>=3", min_ph); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL switch_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_fast();
      int acks = 0, ack_at = -100, bad = 0;
      bit prev = 1'b0;
      sel = 2'd2;
      for (int i = 0; i < 50; i++) begin
         wr_en   = (i == 0);
         wr_ch   = 2'd2;
         wr_half = 8'd0;
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL fast cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (sel_ack === 1'b1) begin acks++; ack_at = i; end
         if (ack_at >= 0 && i > ack_at + 3 && new_clk === prev) bad++;
         prev = new_clk;
         adv();
      end
      wr_en = 1'b0;
      n_vec++; if (acks != 1) begin n_err++; $display("FAIL fast_acks got=%0d exp=1", acks); end
      n_vec++; if (bad != 0)  begin n_err++; $display("FAIL fast_period2 got=%0d stalls exp=0", bad); end
   endtask

   task automatic test_reset_arm();
      bit found = 1'b0;
      sel = 2'd0;
      for (int i = 0; i < 30; i++) begin
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL rstarm_pre cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (m_mode == 2) begin found = 1'b1; break; end
         adv();
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL rstarm_reach_arm got=%0d exp=2", m_mode); end
      RST = 1'b0;
      #1;
      model_reset();
      n_vec++; if (new_clk !== 1'b0) begin n_err++; $display("FAIL rstarm_new_clk got=%b exp=0", new_clk); end
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rstarm_busy got=%b exp=0", busy); end
      n_vec++; if (tick !== '0)      begin n_err++; $display("FAIL rstarm_tick got=%b exp=0", tick); end
      adv();
      RST = 1'b1;
      for (int i = 0; i < 24; i++) begin
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL rstarm_post cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         adv();
      end
   endtask

   task automatic test_enable();
      logic held;
      #1;
      held = new_clk;
      en   = 1'b0;
      for (int i = 0; i < 30; i++) begin
         en = (i >= 10);
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL enable cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         if (i < 10) begin
            n_vec++;
            if (tick !== '0 || new_clk !== held) begin
               n_err++;
               $display("FAIL enable_frozen cyc=%0d got=%b/%b exp=0000/%b", i, tick, new_clk, held);
            end
         end
         adv();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_ch   = SEL_W'($urandom_range(0, NUM_CH - 1));
         wr_half = CNT_W'($urandom_range(0, 6));
         if ($urandom_range(0, 29) == 0) sel = SEL_W'($urandom_range(0, NUM_CH - 1));
         #1;
         n_vec++;
         if ({new_clk, busy, sel_ack, tick} !== exp_out()) begin
            n_err++;
            $display("FAIL random cyc=%0d got=%b exp=%b", i, {new_clk, busy, sel_ack, tick}, exp_out());
         end
         adv();
      end
      wr_en = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_write();
      test_switch();
      test_fast();
      test_reset_arm();
      test_enable();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
